seq_pattern_counter: RTL and testbench

//   Parametrised sequence counter: steps a WIDTH-bit state through binary-up, binary-down, Gray or

---
 rtl/seq_counter_pkg.sv | 32 +++
 rtl/seq_next_table.sv | 58 +++++
 rtl/seq_pattern_counter.sv | 111 +++++++++++
 tb/tb_seq_pattern_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_counter_pkg.sv
// Shared definitions for the sequence pattern counter.
//   - Mode encodings for the 2-bit mode input.
//   - Gray/binary conversion helpers and the default next-state map.
// Helpers work on 32-bit values; callers cast the results down to the state width.
package seq_counter_pkg;

  localparam logic [1:0] MODE_UP    = 2'b00;
  localparam logic [1:0] MODE_DOWN  = 2'b01;
  localparam logic [1:0] MODE_GRAY  = 2'b10;
  localparam logic [1:0] MODE_TABLE = 2'b11;

  // Binary to reflected Gray code.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = 32'd0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Default table entry: every state advances to its successor, wrapping at depth.
  function automatic logic [31:0] default_next(input logic [31:0] i, input logic [31:0] depth);
    return (i + 32'd1) % depth;
  endfunction

endpackage

// File: rtl/seq_next_table.sv
// Next-state table for TABLE mode: DEPTH = 2**WIDTH entries of WIDTH bits.
// Configuration macro: SEQ_TABLE_WR_EN
//   defined   : writable storage, synchronous write, asynchronous read, default map on reset.
//   undefined : constant default map (i+1) mod DEPTH, no storage; write port ignored.
// Ports:
//   clk    in   1      clock
//   reset  in   1      synchronous active-high reset, restores the default map
//   we     in   1      write strobe
//   waddr  in   WIDTH  entry to write
//   wdata  in   WIDTH  next state stored at waddr
//   raddr  in   WIDTH  entry to read (current state)
//   rdata  out  WIDTH  stored next state for raddr (combinational)
module seq_next_table
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** WIDTH;

  logic [WIDTH-1:0] dflt_s [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_dflt
    assign dflt_s[g] = WIDTH'(default_next(32'(g), 32'(DEPTH)));
  end

`ifdef SEQ_TABLE_WR_EN
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Table storage: default map on reset, otherwise single-entry write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= dflt_s[i];
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read returns the pre-edge contents, so a same-cycle write is seen only next cycle.
  assign rdata = mem_r[raddr];
`else
  logic unused_tbl_s;

  assign unused_tbl_s = &{1'b0, clk, reset, we, waddr, wdata};
  assign rdata        = dflt_s[raddr];
`endif

endmodule

// File: rtl/seq_pattern_counter.sv
// Parametrised sequence counter: steps a WIDTH-bit state through binary-up, binary-down,
// Gray or table-driven sequences, flags wrap-around to START and recovers from table self-loops.
// Configuration macro: SEQ_TABLE_WR_EN (writable next-state table; see seq_next_table).
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous active-high reset
//   en         in   1      advance one step
//   mode       in   2      00 UP, 01 DOWN, 10 GRAY, 11 TABLE
//   load       in   1      load count from load_val (beats en)
//   load_val   in   WIDTH  value for load
//   tbl_we     in   1      table write strobe
//   tbl_addr   in   WIDTH  table entry to write
//   tbl_wdata  in   WIDTH  next state for tbl_addr
//   count      out  WIDTH  current state (registered)
//   wrap       out  1      pulse: previous step landed on START
//   illegal    out  1      pulse: previous TABLE step hit a self-loop
module seq_pattern_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int START = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tbl_we,
  input  logic [WIDTH-1:0] tbl_addr,
  input  logic [WIDTH-1:0] tbl_wdata,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] START_VAL = WIDTH'(START);
  localparam logic [WIDTH-1:0] ONE_VAL   = WIDTH'(1);

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             illegal_r;
  logic [WIDTH-1:0] tbl_rdata_s;
  logic [WIDTH-1:0] step_next_s;
  logic             self_loop_s;
  logic [WIDTH-1:0] gray_bin_s;
  logic [WIDTH-1:0] gray_inc_s;

  seq_next_table #(
    .WIDTH (WIDTH)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .waddr (tbl_addr),
    .wdata (tbl_wdata),
    .raddr (count_r),
    .rdata (tbl_rdata_s)
  );

  // Next value for a step in the current mode, plus self-loop detection for TABLE.
  always_comb begin
    step_next_s = count_r;
    self_loop_s = 1'b0;
    // Increment is done in binary at WIDTH bits so it wraps before re-encoding to Gray.
    gray_bin_s  = WIDTH'(gray2bin(32'(count_r)));
    gray_inc_s  = gray_bin_s + ONE_VAL;
    case (mode)
      MODE_UP:   step_next_s = count_r + ONE_VAL;
      MODE_DOWN: step_next_s = count_r - ONE_VAL;
      MODE_GRAY: step_next_s = WIDTH'(bin2gray(32'(gray_inc_s)));
      MODE_TABLE: begin
        if (tbl_rdata_s == count_r) begin
          step_next_s = START_VAL;
          self_loop_s = 1'b1;
        end else begin
          step_next_s = tbl_rdata_s;
          self_loop_s = 1'b0;
        end
      end
      default:   step_next_s = count_r;
    endcase
  end

  // State and flag registers: reset > load > step > hold; flags are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r   <= START_VAL;
      wrap_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else if (load) begin
      count_r   <= load_val;
      wrap_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else if (en) begin
      count_r   <= step_next_s;
      // A self-loop recovery lands on START but is reported as illegal, not as a wrap.
      wrap_r    <= (step_next_s == START_VAL) && !self_loop_s;
      illegal_r <= self_loop_s;
    end else begin
      count_r   <= count_r;
      wrap_r    <= 1'b0;
      illegal_r <= 1'b0;
    end
  end

  assign count   = count_r;
  assign wrap    = wrap_r;
  assign illegal = illegal_r;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Directed self-checking bench for seq_pattern_counter (WIDTH=3, START=0).
// Expected values follow the build: SEQ_TABLE_WR_EN defined or not.
module tb_seq_pattern_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [2:0] load_val;
  logic       tbl_we;
  logic [2:0] tbl_addr;
  logic [2:0] tbl_wdata;
  logic [2:0] count;
  logic       wrap;
  logic       illegal;

  int n_checks;
  int n_fail;

  seq_pattern_counter #(
    .WIDTH (3),
    .START (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .load      (load),
    .load_val  (load_val),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_wdata (tbl_wdata),
    .count     (count),
    .wrap      (wrap),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int c, input int w, input int il);
    check_eq({tag, " count"}, int'(count), c);
    check_eq({tag, " wrap"}, int'(wrap), w);
    check_eq({tag, " illegal"}, int'(illegal), il);
  endtask

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tbl(input logic [2:0] a, input logic [2:0] d);
    tbl_we    = 1'b1;
    tbl_addr  = a;
    tbl_wdata = d;
    tick();
    tbl_we    = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  int src_t[7] = '{0, 1, 3, 6, 2, 5, 4};
  int dst_t[7] = '{1, 3, 6, 2, 5, 4, 0};
  int gray_t[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
  int exp_c;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    en        = 1'b0;
    mode      = 2'b00;
    load      = 1'b0;
    load_val  = 3'd0;
    tbl_we    = 1'b0;
    tbl_addr  = 3'd0;
    tbl_wdata = 3'd0;
    tick();
    tick();
    check_out("reset", 0, 0, 0);
    reset = 1'b0;

    // UP: 1..7,0,1 with wrap only after 7->0
    mode = 2'b00;
    en   = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_out($sformatf("up%0d", i), i % 8, (i == 8) ? 1 : 0, 0);
    end
    en = 1'b0;
    tick();
    check_out("hold", 1, 0, 0);

    // Program a permuted table, return to 0 by load
    for (int i = 0; i < 7; i++) begin
      write_tbl(3'(src_t[i]), 3'(dst_t[i]));
    end
    do_load(3'd0);
    check_out("load0", 0, 0, 0);
    mode = 2'b11;
    en   = 1'b1;
    for (int i = 0; i < 7; i++) begin
`ifdef SEQ_TABLE_WR_EN
      exp_c = dst_t[i];
`else
      exp_c = i + 1;
`endif
      tick();
      check_out($sformatf("tbl%0d", i), exp_c, (exp_c == 0) ? 1 : 0, 0);
    end
    en = 1'b0;

    // Self-loop at 7 recovers to START with illegal, not wrap
    write_tbl(3'd7, 3'd7);
    do_load(3'd7);
    check_out("load7", 7, 0, 0);
    en = 1'b1;
    tick();
`ifdef SEQ_TABLE_WR_EN
    check_out("selfloop", 0, 0, 1);
`else
    check_out("selfloop", 0, 1, 0);
`endif
    en = 1'b0;
    tick();
    check_out("ill_pulse", 0, 0, 0);

    // GRAY from 0
    mode = 2'b10;
    en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out($sformatf("gray%0d", i), gray_t[i], (i == 7) ? 1 : 0, 0);
    end
    en = 1'b0;

    // DOWN from 1
    do_load(3'd1);
    mode = 2'b01;
    en   = 1'b1;
    tick();
    check_out("down0", 0, 1, 0);
    tick();
    check_out("down7", 7, 0, 0);

    // load beats en
    load     = 1'b1;
    load_val = 3'd5;
    tick();
    load     = 1'b0;
    check_out("load_pri", 5, 0, 0);

    // Same-cycle write and TABLE step at 5: read-before-write
    mode      = 2'b11;
    tbl_we    = 1'b1;
    tbl_addr  = 3'd5;
    tbl_wdata = 3'd2;
    tick();
    tbl_we    = 1'b0;
`ifdef SEQ_TABLE_WR_EN
    check_out("rbw_old", 4, 0, 0);
`else
    check_out("rbw_old", 6, 0, 0);
`endif
    en = 1'b0;
    do_load(3'd5);
    en = 1'b1;
    tick();
`ifdef SEQ_TABLE_WR_EN
    check_out("rbw_new", 2, 0, 0);
`else
    check_out("rbw_new", 6, 0, 0);
`endif

    // Corrupt entry 0, then reset mid-sequence (with load asserted) restores default
    en = 1'b0;
    write_tbl(3'd0, 3'd3);
    en       = 1'b1;
    reset    = 1'b1;
    load     = 1'b1;
    load_val = 3'd5;
    tick();
    check_out("mid_reset", 0, 0, 0);
    reset = 1'b0;
    load  = 1'b0;
    tick();
    check_out("post_reset", 1, 0, 0);
    tick();
    check_out("post_reset2", 2, 0, 0);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
